// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - state encoding, error codes and checksum helper for uart_frame_assembler
package uart_frame_pkg;

  localparam int MAX_FRAME_BYTES = 16;
  localparam int MAX_FRAME_W     = 8 * MAX_FRAME_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RESYNC  = 2'd2,
    ST_CHECK   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_PARITY   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

  // XOR of the lowest 'count' bytes of a zero-extended frame
  function automatic logic [7:0] xor_bytes(input logic [MAX_FRAME_W-1:0] data, input int count);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_FRAME_BYTES; i++) begin
      if (i < count) acc = acc ^ data[8*i +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_frame_assembler_gap_timer.sv
// rtl/uart_frame_assembler_gap_timer.sv - saturating inter-byte gap timer (module frame_gap_timer)
module frame_gap_timer #(
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] FINAL_STEP = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || clear) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CNT_W'(1);
    end
  end

  // High during the silent cycle whose edge brings the count to TIMEOUT_CYCLES
  assign expired = enable && (count >= FINAL_STEP);

endmodule

// File: rtl/uart_frame_assembler.sv
// rtl/uart_frame_assembler.sv - assembles FRAME_BYTES uart_rx bytes into one held frame word
// Optional trailing XOR checksum byte: define UART_FRAME_CHECKSUM_EN
module uart_frame_assembler
  import uart_frame_pkg::*;
#(
  parameter int                         FRAME_BYTES    = 2,
  parameter int                         TIMEOUT_CYCLES = 48000,
  parameter logic [8*FRAME_BYTES-1:0]   RESET_VALUE    = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_done,
  input  logic [7:0]                 rx_data,
  input  logic                       parity_error,
  output logic [8*FRAME_BYTES-1:0]   frame_data,
  output logic                       frame_valid,
  output logic                       frame_error,
  output logic [1:0]                 err_code,
  output logic                       busy
);

  localparam int FRAME_W = 8 * FRAME_BYTES;
  localparam int IDX_W   = $clog2(FRAME_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [FRAME_W-1:0]   shadow;
  logic [FRAME_W-1:0]   shadow_ins;
  logic                 expired;

  frame_gap_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_done),
    .enable  (state != ST_IDLE),
    .expired (expired)
  );

  // Shadow with the incoming byte placed at the current index, first byte in the top bits
  always_comb begin
    shadow_ins = shadow;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (idx == IDX_W'(i)) shadow_ins[8*(FRAME_BYTES-1-i) +: 8] = rx_data;
    end
  end

`ifdef UART_FRAME_CHECKSUM_EN
  localparam logic [IDX_W-1:0] CHK_IDX = IDX_W'(FRAME_BYTES);

  logic [7:0]             chk_byte;
  logic [MAX_FRAME_W-1:0] shadow_wide;
  logic                   chk_ok;

  assign shadow_wide = MAX_FRAME_W'(shadow);
  assign chk_ok      = (xor_bytes(shadow_wide, FRAME_BYTES) == chk_byte);
`endif

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      shadow      <= '0;
      frame_data  <= RESET_VALUE;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      err_code    <= ERR_NONE;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_byte    <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        ST_IDLE, ST_COLLECT: begin
          if (rx_done && parity_error) begin
            frame_error <= 1'b1;
            err_code    <= ERR_PARITY;
            shadow      <= '0;
            idx         <= '0;
            state       <= ST_RESYNC;
          end else if (rx_done) begin
`ifdef UART_FRAME_CHECKSUM_EN
            if (idx == CHK_IDX) begin
              chk_byte <= rx_data;
              state    <= ST_CHECK;
            end else begin
              shadow <= shadow_ins;
              idx    <= idx + IDX_W'(1);
              state  <= ST_COLLECT;
            end
`else
            if (idx == LAST_IDX) begin
              frame_data  <= shadow_ins;
              frame_valid <= 1'b1;
              err_code    <= ERR_NONE;
              shadow      <= '0;
              idx         <= '0;
              state       <= ST_IDLE;
            end else begin
              shadow <= shadow_ins;
              idx    <= idx + IDX_W'(1);
              state  <= ST_COLLECT;
            end
`endif
          end else if (expired) begin
            // Only reachable in COLLECT: the timer is held clear while idle
            frame_error <= 1'b1;
            err_code    <= ERR_TIMEOUT;
            shadow      <= '0;
            idx         <= '0;
            state       <= ST_IDLE;
          end
        end
        ST_RESYNC: begin
          if (!rx_done && expired) state <= ST_IDLE;
        end
`ifdef UART_FRAME_CHECKSUM_EN
        ST_CHECK: begin
          if (chk_ok) begin
            frame_data  <= shadow;
            frame_valid <= 1'b1;
            err_code    <= ERR_NONE;
          end else begin
            frame_error <= 1'b1;
            err_code    <= ERR_CHECKSUM;
          end
          shadow <= '0;
          idx    <= '0;
          state  <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// tb/tb_uart_frame_assembler.sv - self-checking bench for uart_frame_assembler (FRAME_BYTES=2, TIMEOUT_CYCLES=100)
// Honours UART_FRAME_CHECKSUM_EN when the build defines it
module tb_uart_frame_assembler;

  localparam int FB = 2;
  localparam int TO = 100;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        parity_error = 1'b0;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_error;
  logic [1:0]  err_code;
  logic        busy;

  int n_assert = 0;
  int n_fail = 0;

  uart_frame_assembler #(
    .FRAME_BYTES    (FB),
    .TIMEOUT_CYCLES (TO),
    .RESET_VALUE    (16'h0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done      (rx_done),
    .rx_data      (rx_data),
    .parity_error (parity_error),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .frame_error  (frame_error),
    .err_code     (err_code),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference model: received bytes queue plus a count of silent cycles
  localparam int M_IDLE = 0, M_COLLECT = 1, M_RESYNC = 2, M_CHECK = 3;
  int              mode = M_IDLE;
  int              silent = 0;
  byte unsigned    q[$];
  logic [7:0]      chk_byte = 8'h00;
  logic [15:0]     exp_data = 16'h0000;
  logic            exp_valid = 1'b0;
  logic            exp_error = 1'b0;
  logic [1:0]      exp_code = 2'd0;
  logic            exp_busy = 1'b0;

  function automatic logic [7:0] q_xor();
    logic [7:0] a;
    a = 8'h00;
    foreach (q[i]) a = a ^ q[i];
    return a;
  endfunction

  task automatic publish();
    exp_data = 16'h0000;
    foreach (q[i]) exp_data = (exp_data << 8) | 16'(q[i]);
    exp_valid = 1'b1;
    exp_code  = 2'd0;
    q.delete();
    mode = M_IDLE;
  endtask

  task automatic fail_frame(input logic [1:0] code, input int next_mode);
    exp_error = 1'b1;
    exp_code  = code;
    q.delete();
    silent = 0;
    mode = next_mode;
  endtask

  always @(posedge clk) begin
    exp_valid = 1'b0;
    exp_error = 1'b0;
    if (reset) begin
      mode = M_IDLE;
      silent = 0;
      q.delete();
      exp_data = 16'h0000;
      exp_code = 2'd0;
    end else begin
      case (mode)
        M_IDLE, M_COLLECT: begin
          if (rx_done && parity_error) begin
            fail_frame(2'd1, M_RESYNC);
          end else if (rx_done) begin
            silent = 0;
            if (CK && q.size() == FB) begin
              chk_byte = rx_data;
              mode = M_CHECK;
            end else begin
              q.push_back(rx_data);
              if (!CK && q.size() == FB) publish();
              else mode = M_COLLECT;
            end
          end else if (mode == M_COLLECT) begin
            silent = silent + 1;
            if (silent == TO) fail_frame(2'd2, M_IDLE);
          end
        end
        M_RESYNC: begin
          silent = rx_done ? 0 : silent + 1;
          if (silent == TO) mode = M_IDLE;
        end
        default: begin
          if (q_xor() == chk_byte) publish();
          else fail_frame(2'd3, M_IDLE);
        end
      endcase
    end
    exp_busy = (mode != M_IDLE);
  end

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      n_assert++;
      if ({frame_data, frame_valid, frame_error, err_code, busy} !==
          {exp_data, exp_valid, exp_error, exp_code, exp_busy}) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t dut data=%h valid=%b error=%b code=%0d busy=%b required data=%h valid=%b error=%b code=%0d busy=%b",
                 $time, frame_data, frame_valid, frame_error, err_code, busy,
                 exp_data, exp_valid, exp_error, exp_code, exp_busy);
      end
      n_assert++;
      if (frame_valid && frame_error) begin
        n_fail++;
        $display("FAIL valid_error_exclusive t=%0t both high, required at most one", $time);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic pe);
    rx_done = 1'b1;
    rx_data = b;
    parity_error = pe;
    @(negedge clk);
    rx_done = 1'b0;
    parity_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1;
    check("reset_data", frame_data, 16'h0000);
    check("reset_valid", frame_valid, 1'b0);
    check("reset_error", frame_error, 1'b0);
    check("reset_code", err_code, 2'd0);
    check("reset_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

`ifdef UART_FRAME_CHECKSUM_EN
    send(8'h0A, 1'b0);
    send(8'hBC, 1'b0);
    send(8'hB6, 1'b0);
    check("ck_not_yet", frame_valid, 1'b0);
    check("ck_busy_check", busy, 1'b1);
    idle(1);
    check("ck_valid", frame_valid, 1'b1);
    check("ck_data", frame_data, 16'h0ABC);
    check("ck_model_data", exp_data, 16'h0ABC);
    send(8'h0A, 1'b0);
    send(8'hBC, 1'b0);
    send(8'h00, 1'b0);
    idle(1);
    check("ck_bad_error", frame_error, 1'b1);
    check("ck_bad_code", err_code, 2'd3);
    check("ck_bad_data", frame_data, 16'h0ABC);
    send(8'h0A, 1'b0);
    send(8'hBC, 1'b0);
    idle(TO);
    check("ck_timeout_error", frame_error, 1'b1);
    check("ck_timeout_code", err_code, 2'd2);
`else
    send(8'h0A, 1'b0);
    idle(19);
    send(8'hBC, 1'b0);
    check("t1_valid", frame_valid, 1'b1);
    check("t1_data", frame_data, 16'h0ABC);
    check("t1_code", err_code, 2'd0);
    check("t1_model_data", exp_data, 16'h0ABC);
    idle(1);
    check("t1_pulse_width", frame_valid, 1'b0);

    send(8'h12, 1'b0);
    idle(TO - 1);
    check("t2_no_early_timeout", frame_error, 1'b0);
    check("t2_busy", busy, 1'b1);
    idle(1);
    check("t2_error", frame_error, 1'b1);
    check("t2_code", err_code, 2'd2);
    check("t2_data_held", frame_data, 16'h0ABC);
    check("t2_idle", busy, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    check("t2_data", frame_data, 16'h3456);
    check("t2_code_clear", err_code, 2'd0);

    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    check("t3_error", frame_error, 1'b1);
    check("t3_code", err_code, 2'd1);
    send(8'h33, 1'b0);
    idle(10);
    send(8'h44, 1'b0);
    check("t3_busy_resync", busy, 1'b1);
    check("t3_ignored", frame_data, 16'h3456);
    idle(TO);
    check("t3_resync_done", busy, 1'b0);
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    check("t3_data", frame_data, 16'h5566);
    check("t3_model_data", exp_data, 16'h5566);

    send(8'hA1, 1'b0);
    idle(TO - 1);
    send(8'hB2, 1'b0);
    check("edge_valid", frame_valid, 1'b1);
    check("edge_no_error", frame_error, 1'b0);
    check("edge_data", frame_data, 16'hA1B2);

    send(8'hC1, 1'b0);
    idle(TO);
    check("late_error", frame_error, 1'b1);
    check("late_code", err_code, 2'd2);

    send(8'h77, 1'b0);
    check("t4_busy_before", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t4_async_data", frame_data, 16'h0000);
    check("t4_async_code", err_code, 2'd0);
    check("t4_async_busy", busy, 1'b0);
    check("t4_async_valid", frame_valid, 1'b0);
    check("t4_async_error", frame_error, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    check("t4_data", frame_data, 16'h0102);
`endif

    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_assembler.md
Name: uart_frame_assembler

Overview:
Parametrised successor to the two-byte UART command capture in the FPGA top. It assembles FRAME_BYTES consecutive uart_rx bytes into one frame, MSB byte first, and publishes it as a held word with a one-cycle valid strobe. Unlike the fixed capture, it recovers from errors. Frames are delimited by an inter-byte gap timeout, and parity errors trigger a resynchronisation wait instead of a dead-end state. It sits between uart_rx and consumers such as the modulator angle input.

Parameters:
FRAME_BYTES, 2, data bytes per frame; legal range 1..16.
TIMEOUT_CYCLES, 48000, clk cycles of silence that end or abort a frame (1 ms at 48 MHz); must be ≥2.
RESET_VALUE, 0, value of frame_data after reset (width 8*FRAME_BYTES).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_done  in  1  one-cycle strobe from uart_rx: byte available
rx_data  in  8  received byte, valid while rx_done=1
parity_error  in  1  qualifies rx_done: byte is corrupt
frame_data  out  8*FRAME_BYTES  last good frame; first received byte in the top bits
frame_valid  out  1  one-cycle pulse when frame_data updates
frame_error  out  1  one-cycle pulse on any frame discard
err_code  out  2  0 none, 1 parity, 2 timeout, 3 checksum; sticky
busy  out  1  high in COLLECT/RESYNC (and CHECK)

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE, byte index=0, gap counter=0, frame_data=RESET_VALUE, frame_valid=0, frame_error=0, err_code=0, busy=0. The partial frame is lost.
- States: IDLE, COLLECT, RESYNC; plus CHECK when the optional feature is enabled.
- IDLE: rx_done with good parity stores the byte into the shadow register at index 0 → COLLECT. rx_done with parity_error → error(1) → RESYNC.
- COLLECT: each good byte is stored at the next index and clears the gap counter.
  - After byte FRAME_BYTES (feature off): frame_data<=shadow and frame_valid=1 on the edge after that rx_done (1-cycle latency); err_code<=0; → IDLE.
  - FRAME_BYTES=1: IDLE completes immediately with the same latency.
  - parity_error byte → error(1) → RESYNC.
  - Gap counter reaches TIMEOUT_CYCLES with no rx_done → error(2) → IDLE.
- RESYNC: every rx_done (good or bad) is discarded and clears the gap counter. When the counter reaches TIMEOUT_CYCLES → IDLE, with no extra error.
- error(n): frame_error=1 for one cycle; err_code<=n; frame_data unchanged; shadow and index cleared.
- Gap counter: width $clog2(TIMEOUT_CYCLES+1); saturates; runs only in COLLECT/RESYNC.
- Simultaneous events: rx_done in the same cycle as the timeout compare wins. The byte is accepted and no timeout is flagged.
- frame_valid and frame_error are never high together.
- err_code holds until the next good frame or the next error.

Optional Feature:
UART_FRAME_CHECKSUM_EN
- Defined: one extra byte follows the data bytes and must equal the XOR of all data bytes. Its rx_done moves COLLECT → CHECK. In CHECK, a match publishes the frame (frame_valid on the next edge, total 2-cycle latency from the checksum rx_done); a mismatch gives error(3). Both outcomes → IDLE. A timeout before the checksum byte gives error(2). busy stays high in CHECK.
- Undefined: no checksum byte, no CHECK state, and err_code never equals 3.

Decomposition:
- Package uart_frame_pkg: state encoding, the four err_code constants, and the checksum XOR function.
- One sub-module, frame_gap_timer: clk, reset, clear, enable in; expired out; parameter TIMEOUT_CYCLES. It mirrors the existing timer block style.

Test Plan:
- FRAME_BYTES=2, TIMEOUT_CYCLES=100. Send 0x0A, then 0xBC 20 cycles later → frame_valid pulse 1 cycle after the second rx_done; frame_data=0x0ABC; err_code=0.
- Send 0x12, stay silent 100 cycles → frame_error and err_code=2 at the 100th cycle; frame_data remains 0x0ABC. Then send 0x34, 0x56 → frame_data=0x3456.
- Send 0x11, then 0x22 with parity_error → frame_error, err_code=1. Send 0x33 and 0x44 within 100 cycles → both ignored, busy=1. After 100 quiet cycles, send 0x55, 0x66 → frame_data=0x5566.
- Assert reset after the first byte 0x77 → all outputs at reset values immediately (async); frame_data=0. Then send 0x01, 0x02 → frame_data=0x0102.
- Send the second byte exactly on the cycle the gap counter hits 100 → frame accepted, no frame_error.
- With UART_FRAME_CHECKSUM_EN: 0x0A, 0xBC, 0xB6 → valid, frame_data=0x0ABC. 0x0A, 0xBC, 0x00 → frame_error, err_code=3, frame_data unchanged.
